// File: rtl/defines_pkg.sv
// Shared defaults and types for the BDF join processing element.
//   PE_WIDTH_DEF      default token width
//   PE_FIFO_DEPTH_DEF default entries per input FIFO
//   PE_LATENCY_DEF    default pipeline depth between join and output
//   pe_stage_t        one pipeline stage (valid + data) at the default width
package defines_pkg;

  localparam int unsigned PE_WIDTH_DEF      = 16;
  localparam int unsigned PE_FIFO_DEPTH_DEF = 2;
  localparam int unsigned PE_LATENCY_DEF    = 15;

  typedef struct packed {
    logic                    valid;
    logic [PE_WIDTH_DEF-1:0] data;
  } pe_stage_t;

endpackage

// File: rtl/pe_in_fifo.sv
// Small circular input FIFO for one join channel.
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (clears count and pointers)
//   push       write push_data at the tail (ignored when full)
//   push_data  token to write
//   pop        drop the head entry (ignored when empty)
//   head_data  current head token
//   empty      no entries held
//   full       FIFO_DEPTH entries held
module pe_in_fifo #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_data = mem_q[rd_ptr_q];

  // Explicit wrap so non-power-of-two depths stay in range.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pe_2in1out.sv
// Two-input, one-output join PE: buffers each input channel in a FIFO, pops one
// token from each when both are available, adds them and delivers the sum
// through a LATENCY-stage stallable pipeline.
//   clk                    rising-edge clock
//   rst                    asynchronous active-low reset
//   data_in_k/valid_in_k   channel-k token and valid (k = 1, 2)
//   ready_in_k             channel-k can accept (low while in reset or full)
//   data_out/valid_out     joined result and valid
//   ready_out              downstream accepts
// Build option: define PE_2IN1OUT_SAT_EN for a saturating adder instead of wrap.
module pe_2in1out
  import defines_pkg::*;
#(
  parameter int unsigned WIDTH      = PE_WIDTH_DEF,
  parameter int unsigned LATENCY    = PE_LATENCY_DEF,
  parameter int unsigned FIFO_DEPTH = PE_FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in_1,
  input  logic             valid_in_1,
  output logic             ready_in_1,
  input  logic [WIDTH-1:0] data_in_2,
  input  logic             valid_in_2,
  output logic             ready_in_2,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_out
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t           stage_q [LATENCY];
  logic [WIDTH-1:0] head_1, head_2, sum_res;
  logic             empty_1, empty_2, full_1, full_2;
  logic             stall, advance, fire;

  // Gating with rst keeps the readys low during reset without waiting for a clock.
  assign ready_in_1 = rst && !full_1;
  assign ready_in_2 = rst && !full_2;

  assign stall   = stage_q[LATENCY-1].valid && !ready_out;
  assign advance = !stall;
  assign fire    = advance && !empty_1 && !empty_2;

  pe_in_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo_1 (
    .clk       (clk),
    .rst       (rst),
    .push      (valid_in_1 && ready_in_1),
    .push_data (data_in_1),
    .pop       (fire),
    .head_data (head_1),
    .empty     (empty_1),
    .full      (full_1)
  );

  pe_in_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo_2 (
    .clk       (clk),
    .rst       (rst),
    .push      (valid_in_2 && ready_in_2),
    .push_data (data_in_2),
    .pop       (fire),
    .head_data (head_2),
    .empty     (empty_2),
    .full      (full_2)
  );

`ifdef PE_2IN1OUT_SAT_EN
  logic [WIDTH:0] sum_full;
  always_comb begin
    sum_full = {1'b0, head_1} + {1'b0, head_2};
    sum_res  = sum_full[WIDTH] ? '1 : sum_full[WIDTH-1:0];
  end
`else
  always_comb begin
    sum_res = head_1 + head_2;
  end
`endif

  // Whole pipeline moves as one; a stalled output freezes every stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(LATENCY); i++) stage_q[i] <= '0;
    end else if (advance) begin
      stage_q[0].valid <= fire;
      stage_q[0].data  <= sum_res;
      for (int i = 1; i < int'(LATENCY); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign valid_out = stage_q[LATENCY-1].valid;
  assign data_out  = stage_q[LATENCY-1].data;

endmodule

// File: tb/tb_pe_2in1out.sv
module tb_pe_2in1out;

  localparam int LAT = 15;

  logic        clk, rst;
  logic [15:0] data_in_1, data_in_2, data_out;
  logic        valid_in_1, valid_in_2, ready_in_1, ready_in_2, valid_out, ready_out;

  pe_2in1out #(
    .WIDTH      (16),
    .LATENCY    (LAT),
    .FIFO_DEPTH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in_1  (data_in_1),
    .valid_in_1 (valid_in_1),
    .ready_in_1 (ready_in_1),
    .data_in_2  (data_in_2),
    .valid_in_2 (valid_in_2),
    .ready_in_2 (ready_in_2),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_out  (ready_out)
  );

  typedef struct {
    logic [15:0] d;
    int          t;
  } tok_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   n_out = 0;
  int   last_lat = 0;
  logic [15:0] last_data = '0;
  bit   chk_lat = 1'b1;
  logic acc1 = 1'b0, acc2 = 1'b0;
  logic prev_stall = 1'b0;
  logic [15:0] prev_data = '0;

  tok_t in1_q[$], in2_q[$];   // tokens still to be presented
  tok_t a1_q[$], a2_q[$];     // accepted tokens awaiting a partner (t = accept edge)
  tok_t exp_q[$];             // expected results (t = accept edge of the later token)

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h (%0d), required 0x%0h (%0d) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  function automatic logic [15:0] model_sum(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef PE_2IN1OUT_SAT_EN
    return s[16] ? 16'hFFFF : s[15:0];
`else
    return s[15:0];
`endif
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int n, input int budget, input string name);
    int k = 0;
    while (n_out < n && k < budget) begin
      step(1);
      k++;
    end
    if (n_out < n) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: timeout, got %0d outputs, required %0d", name, n_out, n);
    end
  endtask

  task automatic push_pair(input logic [15:0] a, input int ta, input logic [15:0] b,
                           input int tb);
    in1_q.push_back('{a, ta});
    in2_q.push_back('{b, tb});
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Input driver: presents queued tokens once their start cycle is reached.
  initial begin
    valid_in_1 = 1'b0;
    valid_in_2 = 1'b0;
    data_in_1  = 16'hDEAD;
    data_in_2  = 16'hDEAD;
    forever begin
      @(posedge clk);
      #1;
      if (acc1 && in1_q.size() > 0) in1_q.delete(0);
      if (acc2 && in2_q.size() > 0) in2_q.delete(0);
      if (in1_q.size() > 0 && in1_q[0].t <= cyc) begin
        data_in_1 = in1_q[0].d; valid_in_1 = 1'b1;
      end else begin
        data_in_1 = 16'hDEAD;   valid_in_1 = 1'b0;
      end
      if (in2_q.size() > 0 && in2_q[0].t <= cyc) begin
        data_in_2 = in2_q[0].d; valid_in_2 = 1'b1;
      end else begin
        data_in_2 = 16'hDEAD;   valid_in_2 = 1'b0;
      end
    end
  end

  // Mid-cycle monitor: records handshakes, pairs tokens, scores outputs.
  initial begin
    tok_t e;
    int   t;
    forever begin
      @(negedge clk);
      acc1 = valid_in_1 && ready_in_1;
      acc2 = valid_in_2 && ready_in_2;
      if (rst) begin
        if (acc1) a1_q.push_back('{data_in_1, cyc + 1});
        if (acc2) a2_q.push_back('{data_in_2, cyc + 1});
        while (a1_q.size() > 0 && a2_q.size() > 0) begin
          t = (a1_q[0].t > a2_q[0].t) ? a1_q[0].t : a2_q[0].t;
          exp_q.push_back('{model_sum(a1_q[0].d, a2_q[0].d), t});
          a1_q.delete(0);
          a2_q.delete(0);
        end
        if (prev_stall) begin
          check("stall_valid_hold", int'(valid_out), 1);
          check("stall_data_hold", int'(data_out), int'(prev_data));
        end
        if (valid_out && ready_out) begin
          n_out++;
          last_data = data_out;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_output: got data 0x%0h, required no output at cycle %0d",
                     data_out, cyc);
          end else begin
            e = exp_q.pop_front();
            last_lat = cyc - e.t;
            check("out_data", int'(data_out), int'(e.d));
            if (chk_lat) check("out_latency", last_lat, LAT);
          end
        end
        prev_stall = valid_out && !ready_out;
        prev_data  = data_out;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    int   n0, base;
    logic [15:0] ra, rb;

    vecs[0] = '{16'h0003, 16'h0005, 16'h0008};
    vecs[2] = '{16'h0000, 16'h0000, 16'h0000};
    vecs[3] = '{16'h1234, 16'h4321, 16'h5555};
    vecs[6] = '{16'h7FFF, 16'h8000, 16'hFFFF};
`ifdef PE_2IN1OUT_SAT_EN
    vecs[1] = '{16'hFFFF, 16'h0002, 16'hFFFF};
    vecs[4] = '{16'h8000, 16'h8000, 16'hFFFF};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
`else
    vecs[1] = '{16'hFFFF, 16'h0002, 16'h0001};
    vecs[4] = '{16'h8000, 16'h8000, 16'h0000};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 16'hFFFE};
`endif

    rst = 1'b0;
    ready_out = 1'b1;
    #1;
    check("reset_valid_out", int'(valid_out), 0);
    check("reset_data_out", int'(data_out), 0);
    check("reset_ready_in_1", int'(ready_in_1), 0);
    check("reset_ready_in_2", int'(ready_in_2), 0);
    step(3);
    rst = 1'b1;
    step(1);
    check("idle_ready_in_1", int'(ready_in_1), 1);
    check("idle_ready_in_2", int'(ready_in_2), 1);

    // Single pairs, one at a time through an empty pipeline.
    for (int i = 0; i < 7; i++) begin
      n0 = n_out;
      push_pair(vecs[i].a, cyc, vecs[i].b, cyc);
      wait_out(n0 + 1, 40, "vec_wait");
      check("vec_data", int'(last_data), int'(vecs[i].exp));
      check("vec_latency", last_lat, LAT);
      step(3);
      check("vec_single_output", n_out, n0 + 1);
    end

    // Skewed arrival: channel 2 five cycles behind channel 1.
    n0 = n_out;
    push_pair(16'h0010, cyc, 16'h0020, cyc + 5);
    wait_out(n0 + 1, 60, "skew_wait");
    check("skew_data", int'(last_data), 16'h0030);
    check("skew_latency", last_lat, LAT);
    step(3);
    check("skew_single_output", n_out, n0 + 1);

    // Backpressure: first result parks at the output, then FIFOs fill.
    chk_lat = 1'b0;
    n0 = n_out;
    ready_out = 1'b0;
    base = cyc;
    push_pair(16'd1, base, 16'd2, base);
    for (int i = 2; i <= 10; i++) push_pair(16'(i), base + 20 + i, 16'(2 * i), base + 20 + i);
    step(40);
    check("bp_valid_out", int'(valid_out), 1);
    check("bp_data_out", int'(data_out), 16'h0003);
    check("bp_ready_in_1", int'(ready_in_1), 0);
    check("bp_ready_in_2", int'(ready_in_2), 0);
    check("bp_no_delivery", n_out, n0);
    ready_out = 1'b1;
    wait_out(n0 + 10, 100, "bp_wait");
    step(5);
    check("bp_count", n_out, n0 + 10);
    check("bp_last_data", int'(last_data), 30);
    chk_lat = 1'b1;

    // Asynchronous reset with four pairs in flight.
    base = cyc;
    for (int i = 0; i < 4; i++) push_pair(16'(i + 1), base + i, 16'(16 * (i + 1)), base + i);
    step(6);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_valid_out", int'(valid_out), 0);
    check("midrst_data_out", int'(data_out), 0);
    check("midrst_ready_in_1", int'(ready_in_1), 0);
    check("midrst_ready_in_2", int'(ready_in_2), 0);
    in1_q.delete();
    in2_q.delete();
    a1_q.delete();
    a2_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    n0 = n_out;
    step(30);
    check("midrst_no_stale", n_out, n0);
    push_pair(16'h0001, cyc, 16'h0001, cyc);
    wait_out(n0 + 1, 40, "midrst_wait");
    check("midrst_new_data", int'(last_data), 16'h0002);

    // Full-rate streaming of random pairs; latency check implies one result per cycle.
    step(3);
    n0 = n_out;
    base = cyc;
    for (int i = 0; i < 100; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      push_pair(ra, base + i, rb, base + i);
    end
    wait_out(n0 + 100, 300, "stream_wait");
    step(5);
    check("stream_count", n_out, n0 + 100);
    check("stream_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
